// File: rtl/sfifo_pkg.sv
// Shared types and helpers for the burst-capable FIFO occupancy tracker.
// Provides the clamp helper, the registered flag bundle and the fill-width helper.
// Pure declarations: no logic, no latency, no backpressure of its own.
package sfifo_pkg;

  // Registered status flags derived from the next fill level.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  // Flag values held while in reset: FIFO is empty.
  localparam flags_t C_FLAGS_RST = '{full: 1'b0, empty: 1'b1,
                                     almost_full: 1'b0, almost_empty: 1'b1};

  // Smaller of two counts; used to clamp requests against data and space.
  function automatic int unsigned f_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Fill-level width for a given depth: must be able to hold depth itself.
  function automatic int C_FILLW(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sfifo_sticky.sv
// Sticky error bit: latches on set, cleared on request, set beats clear.
// Latency: one cycle from set/clear to output.
// No backpressure; samples set/clear every cycle.
module sfifo_sticky
  import sfifo_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  logic r_q;

  // Latch the error; a coincident clear must not hide a fresh event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sfifo_fill_burst.sv
// Occupancy tracker and flag generator for a FIFO taking multi-entry push/pop bursts.
// Latency: accepted counts are combinational; fill, flags and error pulses one cycle.
// Backpressure: requests are clamped to available data/space; the excess raises a pulse.
module sfifo_fill_burst
  import sfifo_pkg::*;
#(
  parameter  int G_FWFT      = 0,
  parameter  int G_MEMDEPTH  = 1024,
  parameter  int G_MAXBURST  = 4,
  localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  localparam int G_CNTWIDTH  = $clog2(G_MAXBURST + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [G_CNTWIDTH-1:0] i_wr_cnt,
  input  logic [G_CNTWIDTH-1:0] i_rd_cnt,
  input  logic [G_ADDRWIDTH:0]  i_af_thresh,
  input  logic [G_ADDRWIDTH:0]  i_ae_thresh,
  input  logic                  i_clr_sticky,
  output logic [G_CNTWIDTH-1:0] o_wr_acc,
  output logic [G_CNTWIDTH-1:0] o_rd_acc,
  output logic [G_ADDRWIDTH:0]  o_fill_level,
  output logic [G_ADDRWIDTH:0]  o_hwm,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_overflow_sticky,
  output logic                  o_underflow_sticky
);

  // One spare bit above the fill width so space/sum never wrap.
  localparam int FW = C_FILLW(G_MEMDEPTH);
  localparam int XW = FW + 1;

  typedef logic [XW-1:0] ext_t;

  localparam ext_t C_DEPTH = ext_t'(G_MEMDEPTH);

  logic [FW-1:0] r_fill;
  logic [FW-1:0] r_hwm;
  flags_t        r_flags;
  logic          r_empty_dly;
  logic          r_ovf;
  logic          r_udf;

  ext_t          w_wr_req;
  ext_t          w_rd_req;
  ext_t          w_fill;
  ext_t          w_rd_acc;
  ext_t          w_space;
  ext_t          w_wr_acc;
  ext_t          w_fill_nxt;
  flags_t        w_flags_nxt;
  logic [FW-1:0] w_hwm_nxt;
  logic          w_ovf_nxt;
  logic          w_udf_nxt;

  // Out-of-range requests are treated as the largest legal burst.
  assign w_wr_req = ext_t'(f_min(32'(i_wr_cnt), 32'(G_MAXBURST)));
  assign w_rd_req = ext_t'(f_min(32'(i_rd_cnt), 32'(G_MAXBURST)));
  assign w_fill   = ext_t'(r_fill);

  // Reads only see data already stored; writes may reuse space freed by this cycle's reads.
  assign w_rd_acc   = ext_t'(f_min(32'(w_rd_req), 32'(w_fill)));
  assign w_space    = C_DEPTH - w_fill + w_rd_acc;
  assign w_wr_acc   = ext_t'(f_min(32'(w_wr_req), 32'(w_space)));
  assign w_fill_nxt = w_fill - w_rd_acc + w_wr_acc;

  assign w_ovf_nxt = (w_wr_req > w_space);
  assign w_udf_nxt = (w_rd_req > w_fill);

  assign o_wr_acc = G_CNTWIDTH'(w_wr_acc);
  assign o_rd_acc = G_CNTWIDTH'(w_rd_acc);

  // Flags come from the next fill so they line up with the registered fill level.
  always_comb begin
    w_flags_nxt              = C_FLAGS_RST;
    w_flags_nxt.full         = (w_fill_nxt == C_DEPTH);
    w_flags_nxt.empty        = (w_fill_nxt == '0);
    w_flags_nxt.almost_full  = (w_fill_nxt >= ext_t'(i_af_thresh));
    w_flags_nxt.almost_empty = (w_fill_nxt <= ext_t'(i_ae_thresh));
  end

  // Peak tracking; a clear restarts the peak from the level being entered.
  always_comb begin
    w_hwm_nxt = r_hwm;
    if (i_clr_sticky) begin
      w_hwm_nxt = w_fill_nxt[FW-1:0];
    end else if (w_fill_nxt > ext_t'(r_hwm)) begin
      w_hwm_nxt = w_fill_nxt[FW-1:0];
    end
  end

  // Occupancy, flags and one-cycle error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill      <= '0;
      r_hwm       <= '0;
      r_flags     <= C_FLAGS_RST;
      r_empty_dly <= 1'b1;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_fill      <= w_fill_nxt[FW-1:0];
      r_hwm       <= w_hwm_nxt;
      r_flags     <= w_flags_nxt;
      r_empty_dly <= r_flags.empty;
      r_ovf       <= w_ovf_nxt;
      r_udf       <= w_udf_nxt;
    end
  end

  sfifo_sticky u_ovf_sticky (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_set   (w_ovf_nxt),
    .i_clr   (i_clr_sticky),
    .o_q     (o_overflow_sticky)
  );

  sfifo_sticky u_udf_sticky (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_set   (w_udf_nxt),
    .i_clr   (i_clr_sticky),
    .o_q     (o_underflow_sticky)
  );

  // In FWFT mode the head word needs an extra cycle to reach the output register.
  assign o_empty        = r_flags.empty | ((G_FWFT != 0) & r_empty_dly);
  assign o_full         = r_flags.full;
  assign o_almost_full  = r_flags.almost_full;
  assign o_almost_empty = r_flags.almost_empty;
  assign o_fill_level   = r_fill;
  assign o_hwm          = r_hwm;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;

endmodule
